// File: rtl/ooo_hazard_ctrl.sv
// Central stall/flush controller for the out-of-order core.
// Collects busy/hazard/redirect indications from every stage and drives
// PC enable, redirect select, per-stage stalls and flushes.
//
// state     | meaning
// ----------+---------------------------------------------------------
// RUN       | normal flow; structural stalls and mispredict redirects
// IF_DRAIN  | fence.i seen; front end held until the ROB empties
// IF_DFLUSH | data cache flush requested, waiting for dflushed
// IF_IFLUSH | instruction cache flush requested, waiting for iflushed
// TRAP      | trap/xRET redirect to priv_pc, waits for fetch to go idle
module ooo_hazard_ctrl #(
  parameter int DRAIN_TIMEOUT = 1023
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        i_mem_busy,
  input  logic        d_mem_busy,
  input  logic        hazard,
  input  logic        rob_full,
  input  logic        rob_empty,
  input  logic        mispredict,
  input  logic        ifence,
  input  logic        dflushed,
  input  logic        iflushed,
  input  logic        trap_req,
  input  logic        ret,
  input  logic [31:0] priv_vector,
  output logic        pc_en,
  output logic        npc_sel,
  output logic        insert_priv_pc,
  output logic        iren,
  output logic [31:0] priv_pc,
  output logic        fetch_decode_flush,
  output logic        decode_execute_flush,
  output logic        execute_commit_flush,
  output logic        stall_fetch_decode,
  output logic        stall_de,
  output logic        stall_ex,
  output logic        stall_au,
  output logic        stall_mu,
  output logic        stall_du,
  output logic        stall_ls,
  output logic        stall_commit,
  output logic        ifence_flush,
  output logic        drain_timeout
);

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    IF_DRAIN  = 3'd1,
    IF_DFLUSH = 3'd2,
    IF_IFLUSH = 3'd3,
    TRAP      = 3'd4
  } state_t;

  localparam logic [9:0] DRAIN_TC  = 10'(DRAIN_TIMEOUT);
  localparam logic [9:0] DRAIN_MAX = 10'h3FF;

  state_t      state_q, state_d;
  logic        pend_redir_q, pend_redir_d;
  logic [31:0] priv_pc_q, priv_pc_d;
  logic [9:0]  drain_cnt_q, drain_cnt_d;
  logic        drain_timeout_q, drain_timeout_d;
  logic        trap_evt;
  logic        struct_stall;
  logic [9:0]  drain_cnt_inc;

  assign priv_pc       = priv_pc_q;
  assign drain_timeout = drain_timeout_q;

  // State register and the few registered quantities
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= RUN;
      pend_redir_q    <= 1'b0;
      priv_pc_q       <= '0;
      drain_cnt_q     <= '0;
      drain_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pend_redir_q    <= pend_redir_d;
      priv_pc_q       <= priv_pc_d;
      drain_cnt_q     <= drain_cnt_d;
      drain_timeout_q <= drain_timeout_d;
    end
  end

  // Next-state and all combinational stall/flush/fetch controls
  always_comb begin
    state_d              = state_q;
    pend_redir_d         = pend_redir_q;
    priv_pc_d            = priv_pc_q;
    drain_cnt_d          = drain_cnt_q;
    drain_timeout_d      = drain_timeout_q;
    pc_en                = 1'b0;
    npc_sel              = 1'b0;
    insert_priv_pc       = 1'b0;
    iren                 = 1'b0;
    fetch_decode_flush   = 1'b0;
    decode_execute_flush = 1'b0;
    execute_commit_flush = 1'b0;
    stall_fetch_decode   = 1'b0;
    stall_de             = 1'b0;
    stall_ex             = 1'b0;
    stall_au             = 1'b0;
    stall_mu             = 1'b0;
    stall_du             = 1'b0;
    stall_ls             = 1'b0;
    stall_commit         = 1'b0;
    ifence_flush         = 1'b0;
    trap_evt             = (trap_req | ret) && (state_q != TRAP);
    struct_stall         = hazard | rob_full;
    drain_cnt_inc        = (drain_cnt_q == DRAIN_MAX) ? drain_cnt_q : drain_cnt_q + 10'd1;

    // Under reset every control output stays low; flops are cleared anyway.
    if (!RST) begin
      if (trap_evt) begin
        // Trap/xRET wins over everything and aborts any fence.i in flight.
        fetch_decode_flush   = 1'b1;
        decode_execute_flush = 1'b1;
        execute_commit_flush = 1'b1;
        priv_pc_d            = priv_vector;
        pend_redir_d         = 1'b0;
        drain_cnt_d          = '0;
        state_d              = TRAP;
      end else begin
        unique case (state_q)
          RUN: begin
            stall_ex = d_mem_busy;
            stall_ls = d_mem_busy;
            if (mispredict) begin
              fetch_decode_flush   = 1'b1;
              decode_execute_flush = 1'b1;
              npc_sel              = 1'b1;
              pc_en                = ~i_mem_busy;
              iren                 = ~i_mem_busy;
              pend_redir_d         = i_mem_busy;
            end else if (pend_redir_q) begin
              // Redirect held until fetch can accept the new PC.
              npc_sel            = 1'b1;
              fetch_decode_flush = 1'b1;
              pc_en              = ~i_mem_busy;
              iren               = ~i_mem_busy;
              if (!i_mem_busy) pend_redir_d = 1'b0;
            end else if (ifence) begin
              stall_fetch_decode = 1'b1;
              stall_de           = 1'b1;
              state_d            = IF_DRAIN;
            end else begin
              stall_fetch_decode = struct_stall;
              stall_de           = struct_stall;
              pc_en              = ~struct_stall & ~i_mem_busy;
              iren               = ~struct_stall & ~i_mem_busy;
            end
          end
          IF_DRAIN: begin
            stall_fetch_decode = 1'b1;
            stall_de           = 1'b1;
            stall_ex           = d_mem_busy;
            stall_ls           = d_mem_busy;
            drain_cnt_d        = drain_cnt_inc;
            if (drain_cnt_inc == DRAIN_TC) drain_timeout_d = 1'b1;
            if (rob_empty) state_d = IF_DFLUSH;
          end
          IF_DFLUSH, IF_IFLUSH: begin
            ifence_flush       = 1'b1;
            stall_fetch_decode = 1'b1;
            stall_de           = 1'b1;
            stall_ex           = d_mem_busy;
            stall_ls           = d_mem_busy;
            if (iflushed && (state_q == IF_IFLUSH || dflushed)) begin
              // Caches clean: drop the stale fetch and restart at the fence.i PC.
              fetch_decode_flush = 1'b1;
              stall_fetch_decode = 1'b0;
              stall_de           = 1'b0;
              pc_en              = 1'b1;
              iren               = 1'b1;
              drain_cnt_d        = '0;
              state_d            = RUN;
            end else if (state_q == IF_DFLUSH && dflushed) begin
              state_d = IF_IFLUSH;
            end
          end
          TRAP: begin
            fetch_decode_flush   = 1'b1;
            decode_execute_flush = 1'b1;
            execute_commit_flush = 1'b1;
            insert_priv_pc       = 1'b1;
            stall_commit         = 1'b1;
            pc_en                = ~i_mem_busy;
            iren                 = ~i_mem_busy;
            if (!i_mem_busy) state_d = RUN;
          end
          default: state_d = RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ooo_hazard_ctrl.sv
// Scoreboard bench for ooo_hazard_ctrl: each driven cycle pushes its
// hand-computed expected output vector; a negedge monitor pops and compares.
module tb_ooo_hazard_ctrl;

  localparam logic [16:0] O_PCEN = 17'h10000;
  localparam logic [16:0] O_NPC  = 17'h08000;
  localparam logic [16:0] O_INS  = 17'h04000;
  localparam logic [16:0] O_IREN = 17'h02000;
  localparam logic [16:0] O_FDF  = 17'h01000;
  localparam logic [16:0] O_DEF  = 17'h00800;
  localparam logic [16:0] O_ECF  = 17'h00400;
  localparam logic [16:0] O_SFD  = 17'h00200;
  localparam logic [16:0] O_SDE  = 17'h00100;
  localparam logic [16:0] O_SEX  = 17'h00080;
  localparam logic [16:0] O_SLS  = 17'h00008;
  localparam logic [16:0] O_SCM  = 17'h00004;
  localparam logic [16:0] O_IFF  = 17'h00002;
  localparam logic [16:0] O_DTO  = 17'h00001;
  localparam logic [16:0] O_FL   = O_FDF | O_DEF | O_ECF;
  localparam logic [16:0] O_GO   = O_PCEN | O_IREN;
  localparam logic [16:0] O_STL  = O_SFD | O_SDE;
  localparam logic [16:0] O_ALL  = 17'h1FFFF;

  logic        clk, rst;
  logic        i_mem_busy, d_mem_busy, hazard, rob_full, rob_empty;
  logic        mispredict, ifence, dflushed, iflushed, trap_req, ret;
  logic [31:0] priv_vector;
  logic        pc_en, npc_sel, insert_priv_pc, iren;
  logic [31:0] priv_pc;
  logic        fetch_decode_flush, decode_execute_flush, execute_commit_flush;
  logic        stall_fetch_decode, stall_de, stall_ex, stall_au, stall_mu;
  logic        stall_du, stall_ls, stall_commit, ifence_flush, drain_timeout;

  typedef struct {
    string       nm;
    logic [16:0] exp;
    logic [16:0] msk;
    logic        pp_chk;
    logic [31:0] pp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  ooo_hazard_ctrl #(.DRAIN_TIMEOUT(8)) dut (
    .CLK(clk), .RST(rst),
    .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy), .hazard(hazard),
    .rob_full(rob_full), .rob_empty(rob_empty), .mispredict(mispredict),
    .ifence(ifence), .dflushed(dflushed), .iflushed(iflushed),
    .trap_req(trap_req), .ret(ret), .priv_vector(priv_vector),
    .pc_en(pc_en), .npc_sel(npc_sel), .insert_priv_pc(insert_priv_pc), .iren(iren),
    .priv_pc(priv_pc),
    .fetch_decode_flush(fetch_decode_flush), .decode_execute_flush(decode_execute_flush),
    .execute_commit_flush(execute_commit_flush),
    .stall_fetch_decode(stall_fetch_decode), .stall_de(stall_de), .stall_ex(stall_ex),
    .stall_au(stall_au), .stall_mu(stall_mu), .stall_du(stall_du), .stall_ls(stall_ls),
    .stall_commit(stall_commit), .ifence_flush(ifence_flush), .drain_timeout(drain_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [16:0] act;
      e = q.pop_front();
      act = {pc_en, npc_sel, insert_priv_pc, iren,
             fetch_decode_flush, decode_execute_flush, execute_commit_flush,
             stall_fetch_decode, stall_de, stall_ex, stall_au, stall_mu, stall_du,
             stall_ls, stall_commit, ifence_flush, drain_timeout};
      checks++;
      if (((act & e.msk) !== (e.exp & e.msk)) || (e.pp_chk && (priv_pc !== e.pp))) begin
        errors++;
        $display("FAIL %s: outputs got %05h want %05h (mask %05h), priv_pc got %08h want %08h",
                 e.nm, act & e.msk, e.exp & e.msk, e.msk, priv_pc, e.pp_chk ? e.pp : priv_pc);
      end
    end
  end

  task automatic step(input string nm, input logic [16:0] e, input logic [31:0] pp);
    q.push_back('{nm, e, O_ALL, 1'b1, pp});
    @(posedge clk); #1;
  endtask

  task automatic step_rst(input string nm);
    q.push_back('{nm, 17'h0, O_ALL & ~O_DTO, 1'b0, 32'h0});
    @(posedge clk); #1;
  endtask

  task automatic clr();
    i_mem_busy = 0; d_mem_busy = 0; hazard = 0; rob_full = 0; rob_empty = 0;
    mispredict = 0; ifence = 0; dflushed = 0; iflushed = 0; trap_req = 0; ret = 0;
    priv_vector = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(posedge clk); #1;

    // Reset held with a hazard present: all outputs low
    hazard = 1;
    step("rst0", 17'h0, 32'h0);
    step("rst1", 17'h0, 32'h0);
    step("rst2", 17'h0, 32'h0);
    rst = 1'b0;
    step("hazard_stall", O_STL, 32'h0);
    hazard = 0;
    step("hazard_clear", O_GO, 32'h0);
    rob_full = 1;
    step("rob_full_stall", O_STL, 32'h0);
    rob_full = 0; d_mem_busy = 1;
    step("dmem_busy", O_GO | O_SEX | O_SLS, 32'h0);
    d_mem_busy = 0; i_mem_busy = 1;
    step("imem_busy", 17'h0, 32'h0);

    // Mispredict while fetch busy for two cycles
    mispredict = 1;
    step("misp_c1", O_FDF | O_DEF | O_NPC, 32'h0);
    mispredict = 0;
    step("misp_c2_pend", O_FDF | O_NPC, 32'h0);
    i_mem_busy = 0;
    step("misp_c3_go", O_FDF | O_NPC | O_GO, 32'h0);
    step("misp_c4_done", O_GO, 32'h0);
    // Mispredict with fetch idle overrides a hazard stall
    mispredict = 1; hazard = 1;
    step("misp_idle", O_FDF | O_DEF | O_NPC | O_GO, 32'h0);
    mispredict = 0; hazard = 0;
    step("misp_idle_after", O_GO, 32'h0);

    // fence.i full sequence
    ifence = 1;
    step("ifn_c1", O_STL, 32'h0);
    ifence = 0;
    step("ifn_drain2", O_STL, 32'h0);
    step("ifn_drain3", O_STL, 32'h0);
    rob_empty = 1;
    step("ifn_drain4", O_STL, 32'h0);
    step("ifn_dflush5", O_STL | O_IFF, 32'h0);
    step("ifn_dflush6", O_STL | O_IFF, 32'h0);
    dflushed = 1;
    step("ifn_dflushed7", O_STL | O_IFF, 32'h0);
    dflushed = 0;
    step("ifn_iflush8", O_STL | O_IFF, 32'h0);
    iflushed = 1;
    step("ifn_resume9", O_FDF | O_GO | O_IFF, 32'h0);
    iflushed = 0;
    step("ifn_run10", O_GO, 32'h0);

    // dflushed and iflushed together in IF_DFLUSH
    ifence = 1;
    step("ifb_c1", O_STL, 32'h0);
    ifence = 0;
    step("ifb_drain", O_STL, 32'h0);
    dflushed = 1; iflushed = 1;
    step("ifb_both", O_FDF | O_GO | O_IFF, 32'h0);
    dflushed = 0; iflushed = 0; rob_empty = 0;
    step("ifb_run", O_GO, 32'h0);

    // Trap during IF_DFLUSH, then trap ignored while in TRAP
    ifence = 1; rob_empty = 1;
    step("trp_if_c1", O_STL, 32'h0);
    ifence = 0;
    step("trp_if_drain", O_STL, 32'h0);
    step("trp_if_dflush", O_STL | O_IFF, 32'h0);
    trap_req = 1; priv_vector = 32'h0000_0100; i_mem_busy = 1;
    step("trp_req", O_FL, 32'h0);
    trap_req = 0; rob_empty = 0;
    step("trp_busy", O_FL | O_INS | O_SCM, 32'h100);
    i_mem_busy = 0; trap_req = 1; priv_vector = 32'h0000_0200;
    step("trp_go_ignore", O_FL | O_INS | O_SCM | O_GO, 32'h100);
    trap_req = 0;
    step("trp_run", O_GO, 32'h100);

    // Trap and mispredict together: trap path only
    trap_req = 1; mispredict = 1; i_mem_busy = 1; priv_vector = 32'h0000_0200;
    step("tm_c1", O_FL, 32'h100);
    trap_req = 0; mispredict = 0; i_mem_busy = 0;
    step("tm_trap", O_FL | O_INS | O_SCM | O_GO, 32'h200);
    step("tm_run_nopend", O_GO, 32'h200);

    // xRET takes the same path
    ret = 1; priv_vector = 32'h0000_0300;
    step("ret_c1", O_FL, 32'h200);
    ret = 0;
    step("ret_trap", O_FL | O_INS | O_SCM | O_GO, 32'h300);
    step("ret_run", O_GO, 32'h300);

    // Drain timeout at 8 cycles
    ifence = 1;
    step("to_c1", O_STL, 32'h300);
    ifence = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) rob_empty = 1;
      step($sformatf("to_drain%0d", i), (i >= 9) ? (O_STL | O_DTO) : O_STL, 32'h300);
    end
    rob_empty = 0; dflushed = 1; iflushed = 1;
    step("to_resume", O_FDF | O_GO | O_IFF | O_DTO, 32'h300);
    dflushed = 0; iflushed = 0;
    step("to_sticky", O_GO | O_DTO, 32'h300);

    // Reset mid fence.i clears state and the sticky timeout
    ifence = 1;
    step("mr_if_c1", O_STL | O_DTO, 32'h300);
    ifence = 0; rst = 1;
    step_rst("mr_if_rst");
    rst = 0;
    step("mr_if_run", O_GO, 32'h0);

    // Reset discards a pending redirect
    mispredict = 1; i_mem_busy = 1;
    step("mr_pd_c1", O_FDF | O_DEF | O_NPC, 32'h0);
    mispredict = 0; rst = 1;
    step_rst("mr_pd_rst");
    rst = 0; i_mem_busy = 0;
    step("mr_pd_run", O_GO, 32'h0);

    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: entries left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
